// File: rtl/imem_load_ctrl_if.sv
// Signal bundle between the instruction-memory load controller and its environment
// (load stream, pipeline fetch port and the memory array port).
interface imem_load_ctrl_if #(
  parameter int AW = 5
);
  // Load stream handshake: a byte transfers on a rising clk edge where byte_valid
  // and byte_ready are both 1; byte_data must be stable while byte_valid is high.
  logic          load_start;
  logic [AW-1:0] load_len;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic [31:0]   fetch_addr;
  logic [31:0]   fetch_instr;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          cpu_stall;
  logic          load_busy;
  logic          load_done;
  logic          addr_err;

  modport master (
    output load_start, load_len, byte_valid, byte_data, fetch_addr, mem_rdata,
    input  byte_ready, fetch_instr, mem_addr, mem_we, mem_wdata, cpu_stall,
           load_busy, load_done, addr_err
  );

  modport slave (
    input  load_start, load_len, byte_valid, byte_data, fetch_addr, mem_rdata,
    output byte_ready, fetch_instr, mem_addr, mem_we, mem_wdata, cpu_stall,
           load_busy, load_done, addr_err
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction memory controller: clears memory after reset, serves zero-latency
// fetches when idle, and loads a program from a big-endian byte stream.
module imem_load_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic                clk,
  input  logic                reset,
  imem_load_ctrl_if.slave     bus,
  output logic [2:0]          o_dbg_state
);

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_LOAD  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_LEN = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   ONE_LEN   = (AW + 1)'(1);

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_clr_cnt;
  logic [AW-1:0] r_word_cnt;
  logic [1:0]    r_byte_cnt;
  logic [31:0]   r_asm;
  logic [AW:0]   r_len;

  logic          w_accept;
  logic          w_last_word;
  logic          w_out_of_range;

  logic          w_byte_ready;
  logic [31:0]   w_fetch_instr;
  logic [AW-1:0] w_mem_addr;
  logic          w_mem_we;
  logic [31:0]   w_mem_wdata;
  logic          w_cpu_stall;
  logic          w_load_busy;
  logic          w_load_done;
  logic          w_addr_err;

  assign w_accept       = (r_state == S_LOAD) && bus.byte_valid;
  assign w_last_word    = (({1'b0, r_word_cnt} + ONE_LEN) == r_len);
  assign w_out_of_range = |bus.fetch_addr[31:AW+2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_CLEAR;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_CLEAR: if (r_clr_cnt == LAST_ADDR) w_next_state = S_IDLE;
      S_IDLE:  if (bus.load_start) w_next_state = S_LOAD;
      S_LOAD:  if (w_accept && (r_byte_cnt == 2'd3)) w_next_state = S_WRITE;
      S_WRITE: w_next_state = w_last_word ? S_DONE : S_LOAD;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clr_cnt  <= '0;
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_len      <= '0;
    end else begin
      case (r_state)
        S_CLEAR: r_clr_cnt <= r_clr_cnt + 1'b1;
        S_IDLE: begin
          if (bus.load_start) begin
            r_len      <= (bus.load_len == '0) ? DEPTH_LEN : {1'b0, bus.load_len};
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
          end
        end
        S_LOAD: begin
          // First byte of a word lands in the most significant lane.
          if (w_accept) begin
            case (r_byte_cnt)
              2'd0:    r_asm[31:24] <= bus.byte_data;
              2'd1:    r_asm[23:16] <= bus.byte_data;
              2'd2:    r_asm[15:8]  <= bus.byte_data;
              default: r_asm[7:0]   <= bus.byte_data;
            endcase
            r_byte_cnt <= r_byte_cnt + 1'b1;
          end
        end
        S_WRITE: if (!w_last_word) r_word_cnt <= r_word_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_byte_ready  = 1'b0;
    w_fetch_instr = '0;
    w_mem_addr    = r_word_cnt;
    w_mem_we      = 1'b0;
    w_mem_wdata   = r_asm;
    w_cpu_stall   = 1'b1;
    w_load_busy   = 1'b0;
    w_load_done   = 1'b0;
    w_addr_err    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_wdata = '0;
        w_mem_addr  = r_clr_cnt;
      end
      S_IDLE: begin
        w_cpu_stall = 1'b0;
        w_mem_addr  = bus.fetch_addr[AW+1:2];
        if (w_out_of_range) w_addr_err = 1'b1;
        else                w_fetch_instr = bus.mem_rdata;
      end
      S_LOAD: begin
        w_load_busy  = 1'b1;
        w_byte_ready = 1'b1;
      end
      S_WRITE: begin
        w_load_busy = 1'b1;
        w_mem_we    = 1'b1;
      end
      S_DONE: begin
        w_load_busy = 1'b1;
        w_load_done = 1'b1;
      end
      default: ;
    endcase
    // State is already CLEAR while reset is low; only the clear write must be held off.
    if (!reset) w_mem_we = 1'b0;
  end

  assign bus.byte_ready  = w_byte_ready;
  assign bus.fetch_instr = w_fetch_instr;
  assign bus.mem_addr    = w_mem_addr;
  assign bus.mem_we      = w_mem_we;
  assign bus.mem_wdata   = w_mem_wdata;
  assign bus.cpu_stall   = w_cpu_stall;
  assign bus.load_busy   = w_load_busy;
  assign bus.load_done   = w_load_done;
  assign bus.addr_err    = w_addr_err;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: reset clear, fetch path, loads, ignored
// load_start and reset during a load.
module tb_imem_load_ctrl;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic clk;
  logic reset;
  logic [2:0] dbg_state;

  int checks;
  int failures;
  int done_cnt;

  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  logic [31:0]   exp_q[$];
  logic [31:0]   exp_words[DEPTH];

  logic [31:0] mem_model[DEPTH];
  logic        rdata_ovr_en;
  logic [31:0] rdata_ovr;

  imem_load_ctrl_if #(.AW(AW)) bus_if ();

  imem_load_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .o_dbg_state (dbg_state)
  );

  assign bus_if.mem_rdata = rdata_ovr_en ? rdata_ovr : mem_model[bus_if.mem_addr];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // write/done monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus_if.mem_we === 1'b1) begin
      wr_addr_q.push_back(bus_if.mem_addr);
      wr_data_q.push_back(bus_if.mem_wdata);
      mem_model[bus_if.mem_addr] <= bus_if.mem_wdata;
    end
    if (bus_if.load_done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_load(input logic [AW-1:0] len);
    bus_if.load_len   = len;
    bus_if.load_start = 1'b1;
    step();
    bus_if.load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    int   guard;
    repeat (gap) step();
    bus_if.byte_valid = 1'b1;
    bus_if.byte_data  = b;
    guard = 0;
    do begin
      @(negedge clk);
      rdy = bus_if.byte_ready;
      step();
      guard++;
    end while (!rdy && guard < 20);
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL send_byte_timeout: byte_ready=%b required=1", rdy);
    end
    bus_if.byte_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (bus_if.cpu_stall !== 1'b0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus_if.cpu_stall !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle_timeout: cpu_stall=%b required=0", bus_if.cpu_stall);
    end
    step();
  endtask

  task automatic check_in_reset(input string tag);
    checks++;
    if ({bus_if.mem_we, bus_if.load_done, bus_if.byte_ready, bus_if.load_busy,
         bus_if.addr_err, bus_if.cpu_stall} !== 6'b000001 || bus_if.fetch_instr !== 32'h0) begin
      failures++;
      $display("FAIL %s_outputs: we/done/rdy/busy/err/stall=%b instr=%h required=000001 instr=0",
               tag, {bus_if.mem_we, bus_if.load_done, bus_if.byte_ready, bus_if.load_busy,
               bus_if.addr_err, bus_if.cpu_stall}, bus_if.fetch_instr);
    end
  endtask

  task automatic check_clear_sweep(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      checks++;
      if (bus_if.mem_we !== 1'b1 || bus_if.mem_addr !== AW'(i) || bus_if.mem_wdata !== 32'h0 ||
          bus_if.cpu_stall !== 1'b1 || bus_if.load_busy !== 1'b0) begin
        failures++;
        $display("FAIL %s_clear[%0d]: we=%b addr=%0d wdata=%h stall=%b busy=%b required we=1 addr=%0d wdata=0 stall=1 busy=0",
                 tag, i, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata, bus_if.cpu_stall,
                 bus_if.load_busy, i);
      end
    end
    @(negedge clk);
    checks++;
    if (bus_if.cpu_stall !== 1'b0 || bus_if.mem_we !== 1'b0 || dbg_state !== 3'd1) begin
      failures++;
      $display("FAIL %s_idle_after_clear: stall=%b we=%b state=%0d required stall=0 we=0 state=1",
               tag, bus_if.cpu_stall, bus_if.mem_we, dbg_state);
    end
    step();
  endtask

  task automatic test_reset();
    bus_if.fetch_addr = 32'h80;
    #2;
    check_in_reset("reset");
    repeat (2) step();
    wr_addr_q.delete(); wr_data_q.delete();
    reset = 1'b1;
    check_clear_sweep("reset");
    checks++;
    if (wr_addr_q.size() != DEPTH) begin
      failures++;
      $display("FAIL reset_write_count: got=%0d required=%0d", wr_addr_q.size(), DEPTH);
    end
  endtask

  task automatic test_fetch();
    rdata_ovr_en = 1'b1;
    rdata_ovr    = 32'h0022_1820;
    bus_if.fetch_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (bus_if.mem_addr !== 5'd4 || bus_if.fetch_instr !== 32'h0022_1820 || bus_if.addr_err !== 1'b0) begin
      failures++;
      $display("FAIL fetch_in_range: addr=%0d instr=%h err=%b required addr=4 instr=00221820 err=0",
               bus_if.mem_addr, bus_if.fetch_instr, bus_if.addr_err);
    end
    step();
    bus_if.fetch_addr = 32'h80;
    @(negedge clk);
    checks++;
    if (bus_if.fetch_instr !== 32'h0 || bus_if.addr_err !== 1'b1) begin
      failures++;
      $display("FAIL fetch_out_of_range: instr=%h err=%b required instr=0 err=1",
               bus_if.fetch_instr, bus_if.addr_err);
    end
    step();
    rdata_ovr_en = 1'b0;
    bus_if.fetch_addr = 32'h0;
  endtask

  task automatic test_load_two();
    logic [7:0] bytes_v[8] = '{8'h8C, 8'h0B, 8'h00, 8'h04, 8'hAC, 8'h0B, 8'h00, 8'h04};
    wr_addr_q.delete(); wr_data_q.delete();
    done_cnt = 0;
    start_load(5'd2);
    @(negedge clk);
    checks++;
    if (bus_if.load_busy !== 1'b1 || bus_if.cpu_stall !== 1'b1 || bus_if.byte_ready !== 1'b1 ||
        bus_if.fetch_instr !== 32'h0) begin
      failures++;
      $display("FAIL load2_busy: busy=%b stall=%b rdy=%b instr=%h required 1 1 1 0",
               bus_if.load_busy, bus_if.cpu_stall, bus_if.byte_ready, bus_if.fetch_instr);
    end
    step();
    for (int i = 0; i < 8; i++) send_byte(bytes_v[i], 0);
    wait_idle(10);
    checks++;
    if (wr_addr_q.size() != 2) begin
      failures++;
      $display("FAIL load2_write_count: got=%0d required=2", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 5'd0 || wr_data_q[0] !== 32'h8C0B_0004) begin
        failures++;
        $display("FAIL load2_word0: addr=%0d data=%h required addr=0 data=8c0b0004", wr_addr_q[0], wr_data_q[0]);
      end
      checks++;
      if (wr_addr_q[1] !== 5'd1 || wr_data_q[1] !== 32'hAC0B_0004) begin
        failures++;
        $display("FAIL load2_word1: addr=%0d data=%h required addr=1 data=ac0b0004", wr_addr_q[1], wr_data_q[1]);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL load2_done_pulses: got=%0d required=1", done_cnt);
    end
  endtask

  task automatic test_full_load();
    logic [7:0]  b;
    logic [31:0] w;
    wr_addr_q.delete(); wr_data_q.delete(); exp_q.delete();
    done_cnt = 0;
    start_load(5'd0);
    for (int i = 0; i < DEPTH; i++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++) begin
        b = 8'($urandom_range(0, 255));
        w = {w[23:0], b};
        send_byte(b, $urandom_range(0, 3));
      end
      exp_q.push_back(w);
      exp_words[i] = w;
    end
    wait_idle(10);
    repeat (5) step();
    checks++;
    if (wr_addr_q.size() != DEPTH) begin
      failures++;
      $display("FAIL full_write_count: got=%0d required=%0d", wr_addr_q.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL full_word[%0d]: addr=%0d data=%h required addr=%0d data=%h",
                   i, wr_addr_q[i], wr_data_q[i], i, exp_q[i]);
        end
      end
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL full_done_pulses: got=%0d required=1", done_cnt);
    end
  endtask

  task automatic test_fetch_boundary();
    bus_if.fetch_addr = 32'h7F;
    @(negedge clk);
    checks++;
    if (bus_if.mem_addr !== 5'd31 || bus_if.fetch_instr !== exp_words[31] || bus_if.addr_err !== 1'b0) begin
      failures++;
      $display("FAIL fetch_last_word: addr=%0d instr=%h err=%b required addr=31 instr=%h err=0",
               bus_if.mem_addr, bus_if.fetch_instr, bus_if.addr_err, exp_words[31]);
    end
    step();
    bus_if.fetch_addr = 32'hFFFF_FFFC;
    @(negedge clk);
    checks++;
    if (bus_if.fetch_instr !== 32'h0 || bus_if.addr_err !== 1'b1) begin
      failures++;
      $display("FAIL fetch_high_addr: instr=%h err=%b required instr=0 err=1",
               bus_if.fetch_instr, bus_if.addr_err);
    end
    step();
    bus_if.fetch_addr = 32'h0;
  endtask

  task automatic test_ignore_start_and_reset();
    wr_addr_q.delete(); wr_data_q.delete();
    done_cnt = 0;
    start_load(5'd2);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    start_load(5'd1);
    send_byte(8'h33, 1);
    send_byte(8'h44, 0);
    repeat (2) step();
    @(negedge clk);
    checks++;
    if (bus_if.byte_ready !== 1'b1 || done_cnt != 0 || dbg_state !== 3'd2) begin
      failures++;
      $display("FAIL ignore_start: rdy=%b done=%0d state=%0d required rdy=1 done=0 state=2",
               bus_if.byte_ready, done_cnt, dbg_state);
    end
    step();
    send_byte(8'h55, 0);
    send_byte(8'h66, 2);
    reset = 1'b0;
    #1;
    check_in_reset("midload_reset");
    checks++;
    if (dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL midload_state: state=%0d required=0", dbg_state);
    end
    repeat (3) step();
    checks++;
    if (wr_addr_q.size() != 1 || wr_data_q[0] !== 32'h1122_3344 || done_cnt != 0) begin
      failures++;
      $display("FAIL midload_writes: count=%0d data=%h done=%0d required count=1 data=11223344 done=0",
               wr_addr_q.size(), wr_data_q[0], done_cnt);
    end
    wr_addr_q.delete(); wr_data_q.delete();
    reset = 1'b1;
    check_clear_sweep("restart");
    checks++;
    if (wr_addr_q.size() != DEPTH || done_cnt != 0) begin
      failures++;
      $display("FAIL restart_writes: count=%0d done=%0d required count=%0d done=0",
               wr_addr_q.size(), done_cnt, DEPTH);
    end
  endtask

  initial begin
    checks = 0; failures = 0; done_cnt = 0;
    reset = 1'b0;
    rdata_ovr_en = 1'b0;
    rdata_ovr = 32'h0;
    bus_if.load_start = 1'b0;
    bus_if.load_len   = '0;
    bus_if.byte_valid = 1'b0;
    bus_if.byte_data  = 8'h0;
    bus_if.fetch_addr = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_model[i] = 32'hDEAD_BEEF;
      exp_words[i] = 32'h0;
    end
    test_reset();
    test_fetch();
    test_load_two();
    test_full_load();
    test_fetch_boundary();
    test_ignore_start_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
